// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the floating-point add/subtract
//                pipeline. Holds the default format widths, the derived word
//                width and bias, the operand class encoding, the exception
//                flag record and the canonical quiet NaN at default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int W_DEF     = 1 + EXP_W_DEF + MAN_W_DEF;
  localparam int BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;

  // Operand classes after unpacking. Subnormals are reported as ZERO.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    NORM = 3'd1,
    INF  = 3'd2,
    QNAN = 3'd3,
    SNAN = 3'd4
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam logic [W_DEF-1:0] CANON_NAN_DEF =
    {1'b0, {EXP_W_DEF{1'b1}}, 1'b1, {(MAN_W_DEF-1){1'b0}}};

  // Classify an operand from summary bits of its exponent and fraction.
  function automatic fp_class_e fp_classify(
    input logic exp_ones,
    input logic exp_zero,
    input logic frac_zero,
    input logic frac_msb
  );
    fp_class_e cls;
    if (exp_ones) begin
      if (frac_zero)     cls = INF;
      else if (frac_msb) cls = QNAN;
      else               cls = SNAN;
    end else if (exp_zero) begin
      cls = ZERO;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fp_lzc
//  Description : Combinational leading-zero counter.
//  Ports       : in_i  [WIDTH-1:0]  value to scan (MSB first)
//                cnt_o [CNT_W-1:0]  number of leading zeros, WIDTH if in_i==0
//  Revision    : 1.0  initial release
// ============================================================================
module fp_lzc #(
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic found;

  always_comb begin
    cnt_o = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_i[i]) begin
        cnt_o = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_pipe
//  Description : Four-stage IEEE-754 style adder/subtractor, round to nearest
//                even, subnormals flushed to zero. One operation per cycle,
//                global stall on output back-pressure.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                number1/number2   operands A and B {sign, exp, frac}
//                op                0 = A+B, 1 = A-B
//                in_valid/in_ready input handshake
//                result/flags      rounded result, {inv, ovf, unf, inexact}
//                out_valid/out_ready output handshake
//  Revision    : 1.0  initial release
// ============================================================================
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = EXP_W_DEF,
  parameter  int MAN_W = MAN_W_DEF,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] number1,
  input  logic [W-1:0] number2,
  input  logic         op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int SIG_W = MAN_W + 1;   // significand with hidden bit
  localparam int XW    = MAN_W + 4;   // significand + guard/round/sticky
  localparam int SW    = MAN_W + 5;   // XW plus carry-out bit
  localparam int LZ_W  = $clog2(SW + 1);
  localparam int EW    = EXP_W + 2;   // exponent with headroom and sign

  localparam logic [W-1:0]     NAN_Q     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W:0]   SHIFT_LIM = (EXP_W+1)'(MAN_W + 3);
  localparam logic [EW-1:0]    EXP_MAX   = {2'b00, {EXP_W{1'b1}}};

  // Whole pipeline advances together unless a result is waiting downstream.
  logic adv;
  logic out_valid_q;
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  // --------------------------------------------------------------------------
  // S1: unpack, classify, resolve specials, order so |X| >= |Y|
  // --------------------------------------------------------------------------
  fp_class_e       cls_a, cls_b;
  logic            sa, sbe, eff_sub_d1, swap_d1;
  logic [W-2:0]    mag_a, mag_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic            spec_d1;
  logic [W-1:0]    spec_res_d1;
  fp_flags_t       spec_flg_d1;

  assign cls_a = fp_classify(&number1[W-2:MAN_W], ~|number1[W-2:MAN_W],
                             ~|number1[MAN_W-1:0], number1[MAN_W-1]);
  assign cls_b = fp_classify(&number2[W-2:MAN_W], ~|number2[W-2:MAN_W],
                             ~|number2[MAN_W-1:0], number2[MAN_W-1]);

  assign sa         = number1[W-1];
  assign sbe        = number2[W-1] ^ op;   // B's sign as it enters the sum
  assign eff_sub_d1 = sa ^ sbe;
  assign exp_a      = number1[W-2:MAN_W];
  assign exp_b      = number2[W-2:MAN_W];
  // Flushed subnormals compare and add as true zeros.
  assign mag_a      = (cls_a == ZERO) ? '0 : number1[W-2:0];
  assign mag_b      = (cls_b == ZERO) ? '0 : number2[W-2:0];
  assign sig_a      = (cls_a == ZERO) ? '0 : {1'b1, number1[MAN_W-1:0]};
  assign sig_b      = (cls_b == ZERO) ? '0 : {1'b1, number2[MAN_W-1:0]};
  assign swap_d1    = mag_b > mag_a;

  always_comb begin
    spec_d1     = 1'b1;
    spec_res_d1 = '0;
    spec_flg_d1 = '0;
    if (cls_a == QNAN || cls_a == SNAN || cls_b == QNAN || cls_b == SNAN) begin
      spec_res_d1         = NAN_Q;
      spec_flg_d1.invalid = (cls_a == SNAN) || (cls_b == SNAN);
    end else if (cls_a == INF && cls_b == INF) begin
      if (eff_sub_d1) begin
        spec_res_d1         = NAN_Q;
        spec_flg_d1.invalid = 1'b1;
      end else begin
        spec_res_d1 = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end else if (cls_a == INF) begin
      spec_res_d1 = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_b == INF) begin
      spec_res_d1 = {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls_a == ZERO && cls_b == ZERO) begin
      spec_res_d1 = {sa & sbe, {(W-1){1'b0}}};
    end else begin
      spec_d1 = 1'b0;
    end
  end

  logic             v1_q, spec1_q, sign1_q, effsub1_q;
  logic [W-1:0]     spec_res1_q;
  fp_flags_t        spec_flg1_q;
  logic [EXP_W-1:0] ex1_q, d1_q;
  logic [SIG_W-1:0] sx1_q, sy1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else if (adv) begin
      v1_q        <= in_valid;
      spec1_q     <= spec_d1;
      spec_res1_q <= spec_res_d1;
      spec_flg1_q <= spec_flg_d1;
      effsub1_q   <= eff_sub_d1;
      sign1_q     <= swap_d1 ? sbe   : sa;
      ex1_q       <= swap_d1 ? exp_b : exp_a;
      d1_q        <= swap_d1 ? (exp_b - exp_a) : (exp_a - exp_b);
      sx1_q       <= swap_d1 ? sig_b : sig_a;
      sy1_q       <= swap_d1 ? sig_a : sig_b;
    end
  end

  // --------------------------------------------------------------------------
  // S2: align Y to X, collapsing shifted-out bits into the sticky position
  // --------------------------------------------------------------------------
  logic [2*XW-1:0] wide_d2, shifted_d2;
  logic [XW-1:0]   ax_d2, ay_d2;

  assign wide_d2    = {sy1_q, 3'b000, {XW{1'b0}}};
  assign shifted_d2 = wide_d2 >> d1_q;
  assign ax_d2      = {sx1_q, 3'b000};

  always_comb begin
    if ({1'b0, d1_q} >= SHIFT_LIM)
      ay_d2 = {{(XW-1){1'b0}}, |sy1_q};
    else
      ay_d2 = shifted_d2[2*XW-1:XW] | {{(XW-1){1'b0}}, |shifted_d2[XW-1:0]};
  end

  logic             v2_q, spec2_q, sign2_q, effsub2_q;
  logic [W-1:0]     spec_res2_q;
  fp_flags_t        spec_flg2_q;
  logic [EXP_W-1:0] ex2_q;
  logic [XW-1:0]    ax2_q, ay2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
    end else if (adv) begin
      v2_q        <= v1_q;
      spec2_q     <= spec1_q;
      spec_res2_q <= spec_res1_q;
      spec_flg2_q <= spec_flg1_q;
      sign2_q     <= sign1_q;
      effsub2_q   <= effsub1_q;
      ex2_q       <= ex1_q;
      ax2_q       <= ax_d2;
      ay2_q       <= ay_d2;
    end
  end

  // --------------------------------------------------------------------------
  // S3: magnitude add/subtract (never negative since |X| >= |Y|), LZ count
  // --------------------------------------------------------------------------
  logic [SW-1:0]   sum_d3;
  logic [LZ_W-1:0] lz_d3;

  assign sum_d3 = effsub2_q ? ({1'b0, ax2_q} - {1'b0, ay2_q})
                            : ({1'b0, ax2_q} + {1'b0, ay2_q});

  fp_lzc #(.WIDTH(SW), .CNT_W(LZ_W)) u_lzc (
    .in_i  (sum_d3),
    .cnt_o (lz_d3)
  );

  logic             v3_q, spec3_q, sign3_q;
  logic [W-1:0]     spec_res3_q;
  fp_flags_t        spec_flg3_q;
  logic [EXP_W-1:0] ex3_q;
  logic [SW-1:0]    sum3_q;
  logic [LZ_W-1:0]  lz3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q <= 1'b0;
    end else if (adv) begin
      v3_q        <= v2_q;
      spec3_q     <= spec2_q;
      spec_res3_q <= spec_res2_q;
      spec_flg3_q <= spec_flg2_q;
      sign3_q     <= sign2_q;
      ex3_q       <= ex2_q;
      sum3_q      <= sum_d3;
      lz3_q       <= lz_d3;
    end
  end

  // --------------------------------------------------------------------------
  // S4: normalise so the leading one sits at the carry position, round, pack
  // --------------------------------------------------------------------------
  logic [SW-1:0]    norm_d4;
  logic [EW-1:0]    exp_n_d4, exp_r_d4;
  logic [SIG_W-1:0] mant_d4;
  logic [MAN_W+1:0] mant_r_d4;
  logic [MAN_W-1:0] frac_d4;
  logic             g_d4, r_d4, s_d4, rup_d4, unf_d4, ovf_d4, inx_d4;
  logic [W-1:0]     res_d4;
  fp_flags_t        flg_d4;

  assign norm_d4   = sum3_q << lz3_q;
  // Leading one at bit SW-1 has weight 2^(ex+1) relative to the hidden bit.
  assign exp_n_d4  = {2'b00, ex3_q} + EW'(1) - EW'(lz3_q);
  assign mant_d4   = norm_d4[SW-1:4];
  assign g_d4      = norm_d4[3];
  assign r_d4      = norm_d4[2];
  assign s_d4      = |norm_d4[1:0];
  assign inx_d4    = g_d4 | r_d4 | s_d4;
  assign rup_d4    = g_d4 & (r_d4 | s_d4 | mant_d4[0]);
  assign mant_r_d4 = {1'b0, mant_d4} + (MAN_W+2)'(rup_d4);
  assign exp_r_d4  = exp_n_d4 + EW'(mant_r_d4[MAN_W+1]);
  assign frac_d4   = mant_r_d4[MAN_W+1] ? mant_r_d4[MAN_W:1] : mant_r_d4[MAN_W-1:0];
  assign unf_d4    = exp_n_d4[EW-1] || (exp_n_d4 == '0);
  assign ovf_d4    = exp_r_d4 >= EXP_MAX;

  always_comb begin
    res_d4 = '0;
    flg_d4 = '0;
    if (spec3_q) begin
      res_d4 = spec_res3_q;
      flg_d4 = spec_flg3_q;
    end else if (sum3_q == '0) begin
      res_d4 = '0;   // exact cancellation
    end else if (unf_d4) begin
      flg_d4.underflow = 1'b1;
      flg_d4.inexact   = 1'b1;
    end else if (ovf_d4) begin
      res_d4          = {sign3_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d4.overflow = 1'b1;
      flg_d4.inexact  = 1'b1;
    end else begin
      res_d4         = {sign3_q, exp_r_d4[EXP_W-1:0], frac_d4};
      flg_d4.inexact = inx_d4;
    end
  end

  logic [W-1:0] result_q;
  fp_flags_t    flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= v3_q;
      if (v3_q) begin
        result_q <= res_d4;
        flags_q  <= flg_d4;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_pipe
//  Description : Self-checking bench for fp_addsub_pipe (single precision).
//                Table of operand/result vectors plus stall and reset
//                sequences; expected results queued at acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_addsub_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;   // {invalid, overflow, underflow, inexact}
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc;
    bit          chk_lat;
    int          tag;
  } sb_item_t;

  logic        clk;
  logic        rst;
  logic [31:0] number1, number2;
  logic        op, in_valid, in_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        out_valid, out_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  vec_t     vecs [22];
  sb_item_t sb [$];
  sb_item_t mon_e;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .number1   (number1),
    .number2   (number2),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called one time unit after a rising edge; returns likewise.
  task automatic issue(input vec_t v, input bit chk_lat, input int tag);
    int g;
    sb_item_t e;
    number1  = v.a;
    number2  = v.b;
    op       = v.op;
    in_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk($sformatf("in_ready_wait[%0d]", tag), {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      e.res = v.res; e.flg = v.flg; e.acc = cyc; e.chk_lat = chk_lat; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: each negedge with out_valid & out_ready is one transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h flags %b, expected none", result, flags);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("result[%0d]", mon_e.tag), result, mon_e.res);
        chk($sformatf("flags[%0d]", mon_e.tag), {28'd0, flags}, {28'd0, mon_e.flg});
        if (mon_e.chk_lat)
          chk($sformatf("latency[%0d]", mon_e.tag), 32'(cyc - mon_e.acc), 32'd4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_r;
    logic [3:0]  held_f;
    int          g;

    vecs[0]  = '{32'h40ADF06F, 32'h40ADEAB3, 1'b1, 32'h3A378000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
    vecs[2]  = '{32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 4'b0000};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    vecs[5]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    vecs[7]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000};
    vecs[8]  = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    vecs[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
    vecs[11] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
    vecs[12] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    vecs[13] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
    vecs[14] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[15] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    vecs[16] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    vecs[17] = '{32'h3F800000, 32'h0C800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[18] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
    vecs[19] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101};
    vecs[20] = '{32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 4'b0000};
    vecs[21] = '{32'h3F800000, 32'hC0000000, 1'b1, 32'h40400000, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; op = 1'b0;
    number1 = '0; number2 = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Table vectors, issued back to back with the output always ready
    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) issue(vecs[i], 1'b1, i);
    drain();

    // Back-pressure: three ops, output blocked for five cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(vecs[20], 1'b0, 100);
    issue(vecs[21], 1'b0, 101);
    issue(vecs[15], 1'b0, 102);
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    held_r = result;
    held_f = flags;
    chk("stall_first_result", held_r, vecs[20].res);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_result_held", result, held_r);
      chk("stall_flags_held", {28'd0, flags}, {28'd0, held_f});
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset with operations in flight
    @(posedge clk); #1;
    issue(vecs[0], 1'b0, 200);
    issue(vecs[1], 1'b0, 201);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width; total word width W = 1+EXP_W+MAN_W (32 at defaults).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 number1  input  W  operand A, IEEE-754 layout {sign, exp, frac}.
REQ-006 number2  input  W  operand B, same layout.
REQ-007 op  input  1  0 = A+B, 1 = A-B.
REQ-008 in_valid  input  1  operands/op valid this cycle.
REQ-009 in_ready  output  1  block accepts operands this cycle.
REQ-010 result  output  W  rounded sum/difference.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result.
REQ-012 out_valid  output  1  result/flags valid.
REQ-013 out_ready  input  1  downstream accepts result.

Function
REQ-014 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-015 Fixed 4-stage pipeline: S1 unpack/classify/swap so |A|>=|B|, effective op = op^signA^signB; S2 align B by exponent difference with guard/round/sticky; S3 add/subtract magnitudes, leading-zero count; S4 normalise, round, pack, flags.
REQ-016 Latency exactly 4 cycles from input transfer to out_valid when out_ready held high; throughput 1 op/cycle.
REQ-017 Global stall: when out_valid=1 and out_ready=0, all stages hold; in_ready = !(out_valid & !out_ready); bubbles are not collapsed.
REQ-018 result, flags held stable while out_valid=1 and out_ready=0.
REQ-019 Alignment shift >= MAN_W+3 yields aligned B = 0 with sticky = OR of all B significand bits.
REQ-020 Rounding: round-to-nearest, ties-to-even only; mantissa carry-out on rounding increments exponent.
REQ-021 Subnormal inputs flushed to signed zero; subnormal results flushed to +0 with underflow=1, inexact=1.
REQ-022 Exact cancellation (nonzero magnitudes equal, effective subtract) -> +0, no flags.
REQ-023 Zero +/- zero: sign = signA & signB' where signB' = signB^op; else +0.
REQ-024 Any NaN input, or inf minus inf (effective subtract) -> canonical quiet NaN {0, all-ones exp, 1 followed by zeros}; invalid=1 only for inf-inf or signalling NaN input.
REQ-025 Single infinity operand -> that infinity with effective sign, no flags.
REQ-026 Exponent overflow after rounding -> signed infinity, overflow=1, inexact=1.
REQ-027 inexact=1 whenever any of guard/round/sticky nonzero before rounding.

Reset
REQ-028 While rst=1 on a rising edge: all stage valid bits cleared, out_valid=0, result=0, flags=0; in_ready=1 from first cycle after reset.
REQ-029 Reset mid-operation discards all in-flight operations; none emerges afterwards.
REQ-030 Stage data registers other than valids and outputs need no reset.

Structure
REQ-031 Package fp_pkg holds EXP_W/MAN_W defaults, derived W and BIAS, class enum {ZERO, NORM, INF, QNAN, SNAN}, flag struct and canonical NaN constant.
REQ-032 Sub-module fp_lzc (parametrised leading-zero counter, combinational) used in S3.
REQ-033 No latches; single always_ff per stage.

Verification
REQ-034 A=0x40ADF06F, B=0x40ADEAB3, op=1 -> result 0x3A378000, flags 0000, out_valid 4 cycles after accept.
REQ-035 A=0x3F800000, B=0x3F800000, op=0 back-to-back with A=0x40000000, B=0xBF800000, op=0 -> 0x40000000 then 0x3F800000 on consecutive cycles.
REQ-036 A=0x7F800000, B=0x7F800000, op=1 -> 0x7FC00000, invalid=1.
REQ-037 A=0x7F7FFFFF, B=0x7F7FFFFF, op=0 -> 0x7F800000, overflow=1, inexact=1.
REQ-038 Three ops issued, out_ready=0 for 5 cycles -> in_ready=0, result held; on release, three results in order, none lost or duplicated.
REQ-039 rst asserted with 2 ops in flight -> out_valid=0 next cycle, no stale result after rst deasserts.
